// File: rtl/res_ram_pkg.sv
// rtl/res_ram_pkg.sv - shared defaults and FSM encoding for the result RAM reader
package res_ram_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rd_skid_buf.sv
// rtl/rd_skid_buf.sv - 2-entry FIFO holding RAM words and their end-of-window flag
module rd_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         push_last,
    input  logic         pop,
    output logic [W-1:0] data,
    output logic         last,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [1:0][W-1:0] mem_data;
    logic [1:0]        mem_last;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        cnt_q;
    logic              do_push;
    logic              do_pop;

    assign empty   = (cnt_q == 2'd0);
    assign full    = (cnt_q == 2'd2);
    assign do_pop  = pop && !empty;
    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_data <= '0;
            mem_last <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_data[wr_ptr] <= push_data;
                mem_last[wr_ptr] <= push_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign data  = mem_data[rd_ptr];
    assign last  = mem_last[rd_ptr] && !empty;
    assign count = cnt_q;

endmodule

// File: rtl/res_ram_reader.sv
// rtl/res_ram_reader.sv - walks a result RAM window onto a valid/ready stream with checksum
module res_ram_reader
    import res_ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   issued_q;
    logic [ADDR_W:0]   last_idx;
    logic              pend_q;
    logic              pend_last_q;
    logic [DATA_W-1:0] sum_q;

    logic              accept;
    logic              pop;
    logic              issue;
    logic              last_issue;
    logic              credit;
    logic [1:0]        occ;

    logic [DATA_W-1:0] head_data;
    logic              head_last;
    logic [1:0]        buf_count;
    logic              buf_full;
    logic              buf_empty;

    assign accept   = (state == ST_IDLE) && start;
    assign pop      = !buf_empty && m_ready;
    assign last_idx = len_q - LEN_ONE;

    // Words held plus the one arriving from the RAM this edge, less the one leaving.
    assign occ    = buf_count + {1'b0, pend_q} - {1'b0, pop};
    assign credit = (occ < 2'd2) && !(buf_full && !pop);

    assign issue      = (state == ST_READ) && credit;
    assign last_issue = issue && (issued_q == last_idx);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = (len == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (last_issue) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && head_last) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            sum_q       <= '0;
        end else begin
            pend_q      <= issue;
            pend_last_q <= last_issue;
            if (accept) begin
                addr_q   <= start_addr;
                len_q    <= len;
                issued_q <= '0;
                sum_q    <= '0;
            end else begin
                if (issue) begin
                    addr_q   <= addr_q + ADDR_ONE;
                    issued_q <= issued_q + LEN_ONE;
                end
                if (pop) begin
                    sum_q <= sum_q + head_data;
                end
            end
        end
    end

    rd_skid_buf #(
        .W(DATA_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (pend_q),
        .push_data (mem_dout),
        .push_last (pend_last_q),
        .pop       (pop),
        .data      (head_data),
        .last      (head_last),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign mem_addr = addr_q;
    assign mem_en   = issue;
    assign m_data   = head_data;
    assign m_valid  = !buf_empty;
    assign m_last   = head_last;
    assign busy     = (state == ST_READ) || (state == ST_DRAIN);
    assign done     = (state == ST_DONE);
    assign checksum = sum_q;

endmodule

// File: tb/tb_res_ram_reader.sv
// tb/tb_res_ram_reader.sv - self-checking bench for res_ram_reader against a window/queue model
module tb_res_ram_reader;
    import res_ram_pkg::*;

    localparam int AW    = DEF_ADDR_W;
    localparam int DW    = DEF_DATA_W;
    localparam int LW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   len = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_en;
    logic [DW-1:0] mem_dout = '0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;

    always #5 clk = ~clk;

    res_ram_reader #(
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .mem_addr   (mem_addr),
        .mem_en     (mem_en),
        .mem_dout   (mem_dout),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) if (mem_en) mem_dout <= ram[mem_addr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic ready_at(input int mode, input int c);
        int pat [6] = '{1, 0, 0, 1, 0, 1};
        case (mode)
            0:       return 1'b1;
            1:       return pat[c % 6] != 0;
            default: return $urandom_range(0, 1) != 0;
        endcase
    endfunction

    task automatic fill(input int kind);
        for (int i = 0; i < DEPTH; i++) begin
            case (kind)
                2:       ram[i] = 8'hFF;
                3:       ram[i] = DW'($urandom);
                default: ram[i] = DW'(i + 1);
            endcase
        end
        if (kind == 1) begin
            ram[62] = 8'd5;
            ram[63] = 8'd6;
            ram[0]  = 8'd7;
            ram[1]  = 8'd8;
        end
    endtask

    // Expected stream is the window contents in address order; timing rules checked per cycle.
    task automatic run_window(input string tag, input int sa, input int ln, input int mode,
                              input int exp_sum, input int glitch_c);
        int   exp_q [$];
        int   sum = 0;
        int   issued = 0;
        int   xfers = 0;
        int   outstanding = 0;
        int   first_valid = -1;
        int   last_xfer = -1;
        int   done_c = -1;
        logic stalled = 1'b0;
        int   held_data = 0;
        int   pop;
        for (int i = 0; i < ln; i++) exp_q.push_back(int'(ram[(sa + i) % DEPTH]));
        for (int c = 0; c < 400 && done_c < 0; c++) begin
            @(negedge clk);
            start      = (c == 0) || (c == glitch_c);
            start_addr = (c == 0) ? AW'(sa) : AW'(sa + 33);
            len        = (c == 0) ? LW'(ln) : LW'(5);
            m_ready    = ready_at(mode, c);
            #1;
            if (stalled) begin
                check({tag, " stall valid held"}, int'(m_valid), 1);
                check({tag, " stall data held"}, int'(m_data), held_data);
            end
            pop = (m_valid && m_ready) ? 1 : 0;
            if (m_valid && first_valid < 0) first_valid = c;
            if (pop != 0) begin
                check({tag, " word expected"}, int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    check({tag, " data"}, int'(m_data), exp_q[0]);
                    check({tag, " last flag"}, int'(m_last), int'(exp_q.size() == 1));
                    sum = (sum + exp_q[0]) % 256;
                    void'(exp_q.pop_front());
                    xfers++;
                    last_xfer = c;
                end
            end
            if (mem_en) begin
                check({tag, " read within window"}, int'(issued < ln), 1);
                check({tag, " read address"}, int'(mem_addr), (sa + issued) % DEPTH);
                check({tag, " read credit"}, int'((outstanding - pop) < 2), 1);
                issued++;
            end
            if (done) done_c = c;
            outstanding = issued - xfers;
            stalled     = m_valid && !m_ready;
            held_data   = int'(m_data);
        end
        check({tag, " done seen before timeout"}, int'(done_c >= 0), 1);
        check({tag, " transfer count"}, xfers, ln);
        check({tag, " done cycle"}, done_c, (ln > 0) ? last_xfer + 1 : 1);
        if (ln > 0) check({tag, " first valid cycle"}, first_valid, 3);
        check({tag, " checksum model"}, int'(checksum), sum);
        if (exp_sum >= 0) check({tag, " checksum value"}, int'(checksum), exp_sum);
        check({tag, " final address"}, int'(mem_addr), (sa + ln) % DEPTH);
        @(negedge clk);
        start = 1'b0;
        #1;
        check({tag, " done one cycle"}, int'(done), 0);
        check({tag, " idle after window"}, int'(busy), 0);
        check({tag, " checksum holds"}, int'(checksum), sum);
    endtask

    typedef struct {
        int    sa;
        int    ln;
        int    mode;
        int    fill_kind;
        int    exp_sum;
        int    glitch;
        string tag;
    } vec_t;

    initial begin
        vec_t vecs [8];
        int   xfers;
        vecs[0] = '{0,  4,  0, 0, 10,  -1, "ramp4"};
        vecs[1] = '{62, 4,  0, 1, 26,  -1, "wrap4"};
        vecs[2] = '{5,  6,  1, 0, 51,  -1, "backpressure6"};
        vecs[3] = '{0,  64, 0, 2, 192, -1, "full64"};
        vecs[4] = '{37, 64, 1, 2, 192, -1, "full64_stall"};
        vecs[5] = '{40, 0,  0, 0, 0,   -1, "len0"};
        vecs[6] = '{3,  8,  0, 0, 60,   2, "start_ignored"};
        vecs[7] = '{63, 1,  1, 0, 64,  -1, "single"};

        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset m_valid", int'(m_valid), 0);
        check("reset mem_en", int'(mem_en), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset checksum", int'(checksum), 0);
        check("reset mem_addr", int'(mem_addr), 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            fill(vecs[i].fill_kind);
            run_window(vecs[i].tag, vecs[i].sa, vecs[i].ln, vecs[i].mode,
                       vecs[i].exp_sum, vecs[i].glitch);
        end

        for (int r = 0; r < 6; r++) begin
            fill(3);
            run_window($sformatf("random%0d", r), $urandom_range(0, DEPTH - 1),
                       $urandom_range(1, DEPTH), 2, -1, -1);
        end

        // Reset landing mid-window after three transfers.
        fill(0);
        xfers = 0;
        for (int c = 0; c < 20 && xfers < 3; c++) begin
            @(negedge clk);
            start      = (c == 0);
            start_addr = '0;
            len        = LW'(8);
            m_ready    = 1'b1;
            #1;
            if (m_valid && m_ready) begin
                check("midreset data", int'(m_data), xfers + 1);
                xfers++;
            end
        end
        check("midreset three words", xfers, 3);
        @(negedge clk);
        start   = 1'b0;
        m_ready = 1'b0;
        rst     = 1'b0;
        #1;
        check("midreset busy before", int'(busy), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset m_valid", int'(m_valid), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset checksum", int'(checksum), 0);
        check("midreset done", int'(done), 0);
        check("midreset mem_en", int'(mem_en), 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            m_ready = 1'b1;
            #1;
            check("midreset no stale word", int'(m_valid), 0);
        end
        run_window("post_reset", 10, 5, 0, 65, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
